// File: rtl/condicionador_botoes.sv
// Key conditioner: 2-FF sync, per-key debounce, pairing window, one-cycle b1/b2 command pulses.
// Latency DEBOUNCE_CICLOS+JANELA_CICLOS+3 cycles (single) / DEBOUNCE_CICLOS+3 (pair); no backpressure, pulses are fire-and-forget.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 2,
    parameter int JANELA_CICLOS   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key1_n,
    input  logic key2_n,
    output logic b1,
    output logic b2,
    output logic ocupado
);
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        JANELA = 2'd1,
        EMITE  = 2'd2,
        SOLTAR = 2'd3
    } estado_t;

    localparam logic [7:0] DB_ULT  = 8'(DEBOUNCE_CICLOS - 1);
    localparam logic [7:0] JAN_ULT = 8'(JANELA_CICLOS - 1);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_deb_n;
    logic [7:0] r_db_cnt [2];
    logic [1:0] w_prs;

    estado_t    r_estado;
    estado_t    w_prox;
    logic [1:0] r_mask;
    logic [1:0] w_mask_prox;
    logic [7:0] r_jan_cnt;
    logic [7:0] w_jan_prox;
    logic       r_b1;
    logic       r_b2;
    logic       r_ocupado;
    logic       w_b1_prox;
    logic       w_b2_prox;
    logic       w_ocup_prox;

    // Bit 0 is key 1, bit 1 is key 2; keys idle high (released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {key2_n, key1_n};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_n <= 2'b11;
            for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb_n[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_ULT) begin
                    r_deb_n[k]  <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 8'd1;
                end
            end
        end
    end

    assign w_prs = ~r_deb_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_mask    <= 2'b00;
            r_jan_cnt <= '0;
            r_b1      <= 1'b0;
            r_b2      <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            r_mask    <= w_mask_prox;
            r_jan_cnt <= w_jan_prox;
            r_b1      <= w_b1_prox;
            r_b2      <= w_b2_prox;
            r_ocupado <= w_ocup_prox;
        end
    end

    always_comb begin
        w_prox      = r_estado;
        w_mask_prox = r_mask;
        w_jan_prox  = r_jan_cnt;
        case (r_estado)
            OCIOSO: begin
                if (&w_prs) begin
                    w_mask_prox = 2'b11;
                    w_prox      = EMITE;
                end else if (|w_prs) begin
                    w_mask_prox = w_prs;
                    w_jan_prox  = '0;
                    w_prox      = JANELA;
                end
            end
            // Releasing the first key here does not cancel; only the partner key or timeout leaves.
            JANELA: begin
                if (|(w_prs & ~r_mask)) begin
                    w_mask_prox = 2'b11;
                    w_prox      = EMITE;
                end else if (r_jan_cnt == JAN_ULT) begin
                    w_prox = EMITE;
                end else begin
                    w_jan_prox = r_jan_cnt + 8'd1;
                end
            end
            EMITE: w_prox = SOLTAR;
            SOLTAR: begin
                if (w_prs == 2'b00) begin
                    w_prox      = OCIOSO;
                    w_mask_prox = 2'b00;
                end
            end
            default: w_prox = OCIOSO;
        endcase
    end

    // Outputs are registered from the next state so they toggle cleanly with the EMITE state.
    always_comb begin
        w_b1_prox   = (w_prox == EMITE) && w_mask_prox[0];
        w_b2_prox   = (w_prox == EMITE) && w_mask_prox[1];
        w_ocup_prox = (w_prox != OCIOSO);
    end

    assign b1      = r_b1;
    assign b2      = r_b2;
    assign ocupado = r_ocupado;
endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 2, consecutive stable cycles to accept a key level change (20 ms at the 100 Hz system clock); legal range 1..255.
REQ-002 SHALL have parameter JANELA_CICLOS, default 5, cycles to wait for the second key before a press is classed single; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key1_n  input  1  raw board key 1, active-low, asynchronous to clk.
REQ-006 SHALL have port key2_n  input  1  raw board key 2, active-low, asynchronous to clk.
REQ-007 SHALL have port b1  output  1  one-cycle command pulse for key 1, feeds the main controller b1.
REQ-008 SHALL have port b2  output  1  one-cycle command pulse for key 2, feeds the main controller b2.
REQ-009 SHALL have port ocupado  output  1  high whenever the FSM is not in OCIOSO.

Function
REQ-010 SHALL pass each key through a two-flip-flop synchronizer before any other logic.
REQ-011 SHALL debounce each key independently: counter clears while synced level equals the debounced level, otherwise increments; debounced level flips on the DEBOUNCE_CICLOS-th consecutive differing edge.
REQ-012 SHALL treat any synced glitch shorter than DEBOUNCE_CICLOS cycles as no event.
REQ-013 SHALL implement FSM states OCIOSO, JANELA, EMITE, SOLTAR, plus a 2-bit mask register {k2,k1}.
REQ-014 OCIOSO: both debounced pressed -> mask=11, go EMITE; exactly one pressed -> mask=that key, window counter=0, go JANELA; none -> stay.
REQ-015 JANELA: other key debounced pressed -> mask=11, go EMITE; else if counter==JANELA_CICLOS-1 -> go EMITE; else counter+1.
REQ-016 JANELA: release of the first key before timeout SHALL NOT cancel; the press still emits at timeout.
REQ-017 EMITE: b1=mask[0], b2=mask[1] for exactly one clk cycle, then go SOLTAR.
REQ-018 SOLTAR: stay until both debounced keys released, then go OCIOSO; presses in SOLTAR SHALL be ignored (no pulse).
REQ-019 b1 and b2 SHALL be zero in every state except EMITE and SHALL be driven glitch-free from registers.
REQ-020 Latency, edge 0 = first edge sampling the press: single press pulses in cycle after edge DEBOUNCE_CICLOS+JANELA_CICLOS+2; simultaneous press pulses in cycle after edge DEBOUNCE_CICLOS+2.
REQ-021 At most one command (b1, b2 or both) SHALL be emitted per press-and-release episode.

Reset
REQ-022 rst high SHALL immediately force b1=0, b2=0, ocupado=0, state=OCIOSO, mask=00, all counters=0, synchronizer and debounced levels=released.
REQ-023 rst mid-operation (any state) SHALL discard pending mask with no pulse; a key held through reset SHALL be seen as a new press after release of rst.

Verification
REQ-024 Key1 low held 20 cycles, defaults -> b1=1,b2=0 exactly one cycle, after edge 9; ocupado high until debounced release.
REQ-025 Both keys low same cycle -> b1=b2=1 same single cycle, after edge 4; no separate single pulses.
REQ-026 Key1 low at edge 0, key2 low at edge 3 -> single b1=b2=1 pulse after edge 7.
REQ-027 Key1 bounced low/high every cycle for 10 cycles then high -> no pulse, ocupado stays 0.
REQ-028 Key2 held, rst pulsed at edge 6 (in JANELA) -> no pulse during/after reset edge; with key2 still held, b2 pulse 9 cycles after rst release.
REQ-029 Key1 held 30 cycles, key2 pressed/released during SOLTAR -> only the initial b1 pulse; next key1 press after full release yields a new b1 pulse.
